// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core M1 stage: memory op encodings, E->M1 and M1->M2 bundles,
// the M1 request FSM state enum, and small helpers for offset/alignment handling.
package letc_core_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = XLEN / 8;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [4:0]        reg_idx_t;
    typedef logic [MASK_W-1:0] byte_mask_t;

    typedef enum logic [1:0] {
        MEM_OP_NOP   = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2,
        MEM_OP_AMO   = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [3:0] {
        AMO_OP_SWAP = 4'd0,
        AMO_OP_ADD  = 4'd1,
        AMO_OP_XOR  = 4'd2,
        AMO_OP_AND  = 4'd3,
        AMO_OP_OR   = 4'd4,
        AMO_OP_MIN  = 4'd5,
        AMO_OP_MAX  = 4'd6,
        AMO_OP_MINU = 4'd7,
        AMO_OP_MAXU = 4'd8
    } amo_alu_op_e;

    typedef enum logic [1:0] {
        M1_IDLE = 2'd0,
        M1_REQ  = 2'd1,
        M1_HELD = 2'd2
    } m1_state_e;

    typedef struct packed {
        word_t       pc;
        reg_idx_t    rd_idx;
        logic        rd_we;
        word_t       alu_result;
        word_t       rs2_val;
        mem_op_e     mem_op;
        mem_size_e   mem_size;
        amo_alu_op_e amo_op;
    } e_to_m1_s;

    typedef struct packed {
        word_t       pc;
        reg_idx_t    rd_idx;
        logic        rd_we;
        word_t       alu_result;
        word_t       rs2_val;
        mem_op_e     mem_op;
        mem_size_e   mem_size;
        amo_alu_op_e amo_op;
        logic [1:0]  byte_off;
        logic        misaligned;
    } m1_to_m2_s;

    // Half needs an even offset, word needs offset zero.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        logic result;
        case (size)
            MEM_SIZE_HALF: result = off[0];
            MEM_SIZE_WORD: result = (off != 2'b00);
            default:       result = 1'b0;
        endcase
        return result;
    endfunction

    // Round an offset down to the natural boundary of the access size.
    function automatic logic [1:0] aligned_off(input mem_size_e size, input logic [1:0] off);
        logic [1:0] result;
        case (size)
            MEM_SIZE_BYTE: result = off;
            MEM_SIZE_HALF: result = {off[1], 1'b0};
            default:       result = 2'b00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/letc_core_store_align.sv
// Combinational store lane aligner: shifts rs2 data into its byte lanes and builds the byte mask.
module letc_core_store_align
    import letc_core_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  off,
    input  word_t       rs2_val,
    output word_t       wdata,
    output byte_mask_t  wmask
);

    always_comb begin
        case (size)
            MEM_SIZE_BYTE: wmask = 4'b0001 << off;
            MEM_SIZE_HALF: wmask = 4'b0011 << off;
            default:       wmask = 4'b1111;
        endcase
    end

    assign wdata = rs2_val << {off, 3'b000};

endmodule

// File: rtl/letc_core_stage_memory1.sv
// LETC M1 stage: captures E's bundle, issues dmem requests over valid/ready, forwards to M2.
// Optional LETC_CORE_M1_MISALIGN_CHECK_EN: misaligned accesses skip the request and are flagged.
module letc_core_stage_memory1
    import letc_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    output logic        m1_ready,
    input  logic        m1_flush,
    input  logic        m1_stall,

    input  logic        e_to_m1_valid,
    input  e_to_m1_s    e_to_m1,

    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output word_t       dmem_req_addr,
    output logic        dmem_req_wen,
    output word_t       dmem_req_wdata,
    output byte_mask_t  dmem_req_wmask,
    output mem_size_e   dmem_req_size,
    output amo_alu_op_e dmem_req_amo,

    output logic        m1_to_m2_valid,
    output m1_to_m2_s   m1_to_m2
);

    logic       valid_reg;
    e_to_m1_s   inst_reg;
    m1_state_e  state_reg;
    m1_state_e  state_next;

    logic       is_mem;
    logic       misaligned;
    logic       fault;
    logic       handshake;
    logic [1:0] byte_off;
    logic [1:0] req_off;

    // Flush beats stall so a killed instruction can never re-issue its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (m1_flush) begin
            valid_reg <= 1'b0;
        end else if (!m1_stall && m1_ready) begin
            valid_reg <= e_to_m1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!m1_stall && m1_ready) begin
            inst_reg <= e_to_m1;
        end
    end

    assign byte_off = inst_reg.alu_result[1:0];
    assign is_mem   = (inst_reg.mem_op != MEM_OP_NOP);

`ifdef LETC_CORE_M1_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(inst_reg.mem_size, byte_off);
    assign fault      = is_mem && misaligned;
    assign req_off    = byte_off;
`else
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
    assign req_off    = aligned_off(inst_reg.mem_size, byte_off);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= M1_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // IDLE covers the first cycle of a fresh request; REQ means it has been waiting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            M1_IDLE, M1_REQ: begin
                if (m1_flush) begin
                    state_next = M1_IDLE;
                end else if (handshake) begin
                    state_next = m1_stall ? M1_HELD : M1_IDLE;
                end else begin
                    state_next = dmem_req_valid ? M1_REQ : M1_IDLE;
                end
            end
            M1_HELD: begin
                if (m1_flush || !m1_stall) begin
                    state_next = M1_IDLE;
                end
            end
            default: state_next = M1_IDLE;
        endcase
    end

    always_comb begin
        dmem_req_valid = 1'b0;
        case (state_reg)
            M1_IDLE, M1_REQ: dmem_req_valid = valid_reg && is_mem && !fault;
            default:         dmem_req_valid = 1'b0;
        endcase
        m1_to_m2_valid = valid_reg && !m1_flush && !m1_stall
                      && (!is_mem || fault || (dmem_req_valid && dmem_req_ready)
                          || (state_reg == M1_HELD));
    end

    assign handshake = dmem_req_valid && dmem_req_ready;
    assign m1_ready  = !(dmem_req_valid && !dmem_req_ready);

    assign dmem_req_addr = {inst_reg.alu_result[XLEN-1:2], req_off};
    assign dmem_req_wen  = (inst_reg.mem_op == MEM_OP_STORE);
    assign dmem_req_size = inst_reg.mem_size;
    assign dmem_req_amo  = inst_reg.amo_op;

    letc_core_store_align u_store_align (
        .size    (inst_reg.mem_size),
        .off     (req_off),
        .rs2_val (inst_reg.rs2_val),
        .wdata   (dmem_req_wdata),
        .wmask   (dmem_req_wmask)
    );

    always_comb begin
        m1_to_m2.pc         = inst_reg.pc;
        m1_to_m2.rd_idx     = inst_reg.rd_idx;
        m1_to_m2.rd_we      = inst_reg.rd_we;
        m1_to_m2.alu_result = inst_reg.alu_result;
        m1_to_m2.rs2_val    = inst_reg.rs2_val;
        m1_to_m2.mem_op     = inst_reg.mem_op;
        m1_to_m2.mem_size   = inst_reg.mem_size;
        m1_to_m2.amo_op     = inst_reg.amo_op;
        m1_to_m2.byte_off   = byte_off;
        m1_to_m2.misaligned = misaligned;
    end

endmodule
